// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: access types, EX/MEM control bit
// positions and the memory-stage FSM state type.
package mips_pkg;

  localparam logic [2:0] FN_B  = 3'b000;
  localparam logic [2:0] FN_H  = 3'b001;
  localparam logic [2:0] FN_W  = 3'b010;
  localparam logic [2:0] FN_BU = 3'b100;
  localparam logic [2:0] FN_HU = 3'b101;

  localparam int unsigned WB_REG_WRITE  = 1;
  localparam int unsigned WB_MEM_TO_REG = 0;

  localparam int unsigned M_READ  = 2;
  localparam int unsigned M_WRITE = 1;
  localparam int unsigned M_RSVD  = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mas_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory handshake bus between the memory-access stage and data memory.
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ready, dm_rdata
  );
endinterface

// File: rtl/mem_access_stage_lsu_align.sv
// Combinational byte-lane logic: store lane replication/enables, load
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import mips_pkg::*;
(
  input  logic [2:0]  i_fn,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_access,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_store_be,
  output logic [31:0] o_store_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bad;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Unsigned codes share the lane layout of their signed counterparts on stores.
  always_comb begin
    o_store_be    = 4'b1111;
    o_store_wdata = i_wdata;
    o_load_data   = i_rdata;
    w_bad         = 1'b0;
    case (i_fn)
      FN_B, FN_BU: begin
        o_store_be    = 4'b0001 << i_addr_lo;
        o_store_wdata = {4{i_wdata[7:0]}};
        o_load_data   = (i_fn == FN_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      end
      FN_H, FN_HU: begin
        o_store_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_store_wdata = {2{i_wdata[15:0]}};
        o_load_data   = (i_fn == FN_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        w_bad         = i_addr_lo[0];
      end
      FN_W: begin
        w_bad = (i_addr_lo != 2'b00);
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
    o_misalign = i_access & w_bad;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: data-memory handshake with wait/timeout FSM,
// alignment exceptions and the MEM/WB pipeline register.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                r,
  input  logic [1:0]          ex_wb,
  input  logic [2:0]          ex_m,
  input  logic [2:0]          ex_fn,
  input  logic [31:0]         ex_alu,
  input  logic [31:0]         ex_wdata,
  input  logic [4:0]          ex_rd,
  mem_access_stage_if.master  dm,
  output logic                stall,
  output logic                exc_misalign,
  output logic                exc_bus,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic [31:0]         wb_rdata,
  output logic [31:0]         wb_alu,
  output logic [4:0]          wb_rd
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  mas_state_t  r_state;
  logic [CW-1:0] r_cnt;

  logic        w_access, w_read, w_write, w_go, w_abort, w_bubble;
  logic        w_misalign;
  logic [3:0]  w_store_be;
  logic [31:0] w_store_wdata, w_load_data;
  logic        w_unused;

  assign w_unused = ex_m[M_RSVD];
  assign w_access = ex_m[M_READ] | ex_m[M_WRITE];
  assign w_read   = ex_m[M_READ];
  assign w_write  = ex_m[M_WRITE] & ~ex_m[M_READ];

  lsu_align u_lsu_align (
    .i_fn          (ex_fn),
    .i_addr_lo     (ex_alu[1:0]),
    .i_access      (w_access),
    .i_wdata       (ex_wdata),
    .i_rdata       (dm.dm_rdata),
    .o_store_be    (w_store_be),
    .o_store_wdata (w_store_wdata),
    .o_load_data   (w_load_data),
    .o_misalign    (w_misalign)
  );

  // IDLE request cycle plus WAIT counts 0..TIMEOUT-3 gives TIMEOUT-1 stalled cycles.
  assign w_go    = r & w_access & ~w_misalign;
  assign w_abort = w_go & (r_state == S_WAIT) & ~dm.dm_ready & (r_cnt == CW'(TIMEOUT - 2));

  assign dm.dm_req   = w_go & ~w_abort;
  assign dm.dm_we    = dm.dm_req & w_write;
  assign dm.dm_addr  = {ex_alu[31:2], 2'b00};
  assign dm.dm_be    = w_read ? 4'b1111 : w_store_be;
  assign dm.dm_wdata = w_store_wdata;

  assign stall        = w_go & ~dm.dm_ready & ~w_abort;
  assign exc_misalign = r & w_misalign;
  assign exc_bus      = w_abort;
  assign w_bubble     = stall | w_misalign | w_abort;

  always_ff @(posedge clk) begin
    if (!r) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rdata      <= '0;
      wb_alu        <= '0;
      wb_rd         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (stall) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (stall) r_cnt <= r_cnt + 1'b1;
          else       r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_bubble) begin
        wb_reg_write  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
        wb_rdata      <= '0;
        wb_alu        <= '0;
        wb_rd         <= '0;
      end else begin
        wb_reg_write  <= ex_wb[WB_REG_WRITE];
        wb_mem_to_reg <= ex_wb[WB_MEM_TO_REG];
        wb_rdata      <= w_read ? w_load_data : '0;
        wb_alu        <= ex_alu;
        wb_rd         <= ex_rd;
      end
    end
  end

endmodule
